hazard_ctrl: RTL and testbench

- Pipeline hazard controller for the 5-stage MIPS core.
- Generates stall/flush controls for the F/D, D/E and E/M pipeline registers, and forwarding selects for the E-stage ALU operands and D-stage branch comparator.
- Sequences the multi-cycle mult/div unit: freezes the front of the pipeline while the unit is busy, then pulses a HI/LO write-enable.

---
 rtl/mips_hazard_pkg.sv | 26 ++
 rtl/md_stall_fsm.sv | 63 ++++++
 rtl/hazard_ctrl.sv | 131 +++++++++++++
 tb/tb_hazard_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_hazard_pkg.sv
// Shared types and constants for the MIPS pipeline hazard controller.
// Optional build macro HAZARD_PERF_EN enables the stall performance counters.
package mips_hazard_pkg;

    // Mult/div sequencer states
    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } md_state_t;

    // Forwarding mux selects for the E-stage ALU operands
    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    // Default multi-cycle unit latencies and counter width
    localparam int MUL_CYCLES_DEF = 4;
    localparam int DIV_CYCLES_DEF = 32;
    localparam int CNT_W_DEF      = 6;

    // Register $0 is hard-wired, so it never creates a dependency
    function automatic logic regMatch(input logic [4:0] a, input logic [4:0] b);
        return (a != 5'd0) && (a == b);
    endfunction

endpackage

// File: rtl/md_stall_fsm.sv
// Mult/div sequencer: stalls the front of the pipeline for exactly N cycles
// (N = MUL_CYCLES or DIV_CYCLES) and then pulses the HI/LO write enable in the
// cycle the instruction leaves E.
module md_stall_fsm
    import mips_hazard_pkg::*;
#(
    parameter int MUL_CYCLES = MUL_CYCLES_DEF,
    parameter int DIV_CYCLES = DIV_CYCLES_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic mdstartE,
    input  logic mdisdivE,
    output logic mdstall,
    output logic mdbusy,
    output logic hilo_weE
);

    // The start cycle itself is the first stall, so the counter is loaded with N-1
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

    md_state_t        stateReg;
    logic [CNT_W-1:0] cntReg;
    logic             cntZero;

    assign cntZero = (cntReg == '0);

    // State and down-counter; the release cycle returns to IDLE even though
    // mdstartE is still high, so the same instruction never restarts the unit
    always_ff @(posedge clk) begin
        if (reset) begin
            stateReg <= IDLE;
            cntReg   <= '0;
        end else begin
            case (stateReg)
                IDLE: begin
                    if (mdstartE) begin
                        cntReg   <= mdisdivE ? DIV_LOAD : MUL_LOAD;
                        stateReg <= BUSY;
                    end
                end
                BUSY: begin
                    if (!cntZero) begin
                        cntReg <= cntReg - 1'b1;
                    end else begin
                        stateReg <= IDLE;
                    end
                end
                default: begin
                    stateReg <= IDLE;
                    cntReg   <= '0;
                end
            endcase
        end
    end

    assign mdbusy   = (stateReg == BUSY);
    assign mdstall  = ((stateReg == IDLE) && mdstartE) || ((stateReg == BUSY) && !cntZero);
    assign hilo_weE = (stateReg == BUSY) && cntZero;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage MIPS core: forwarding selects,
// load-use / branch stalls, and mult/div front-end freeze.
// Optional build macro HAZARD_PERF_EN adds per-cause stall counters.
module hazard_ctrl
    import mips_hazard_pkg::*;
#(
    parameter int MUL_CYCLES = MUL_CYCLES_DEF,
    parameter int DIV_CYCLES = DIV_CYCLES_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  rsD,
    input  logic [4:0]  rtD,
    input  logic [4:0]  rsE,
    input  logic [4:0]  rtE,
    input  logic [4:0]  writeregE,
    input  logic [4:0]  writeregM,
    input  logic [4:0]  writeregW,
    input  logic        RegWriteE,
    input  logic        RegWriteM,
    input  logic        RegWriteW,
    input  logic        MemtoRegE,
    input  logic        MemtoRegM,
    input  logic        branchD,
    input  logic        mdstartE,
    input  logic        mdisdivE,
    output logic        stallF,
    output logic        stallD,
    output logic        stallE,
    output logic        flushE,
    output logic        flushM,
    output logic [1:0]  forwardAE,
    output logic [1:0]  forwardBE,
    output logic        forwardAD,
    output logic        forwardBD,
    output logic        mdbusy,
    output logic        hilo_weE
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0] lw_stall_cnt,
    output logic [31:0] br_stall_cnt,
    output logic [31:0] md_stall_cnt
`endif
);

    logic [4:0] srcE [2];
    logic [4:0] srcD [2];
    logic [1:0] fwdE [2];
    logic       fwdD [2];
    logic       lwstall;
    logic       brstall;
    logic       mdstall;

    assign srcE[0] = rsE;
    assign srcE[1] = rtE;
    assign srcD[0] = rsD;
    assign srcD[1] = rtD;

    // Operand A (index 0) and B (index 1) share the same forwarding rules;
    // the newer M-stage result wins over W
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fwd
            assign fwdE[gi] = (RegWriteM && regMatch(writeregM, srcE[gi])) ? FWD_M :
                              (RegWriteW && regMatch(writeregW, srcE[gi])) ? FWD_W : FWD_RF;
            assign fwdD[gi] = RegWriteM && regMatch(writeregM, srcD[gi]);
        end
    endgenerate

    assign forwardAE = fwdE[0];
    assign forwardBE = fwdE[1];
    assign forwardAD = fwdD[0];
    assign forwardBD = fwdD[1];

    // Load-use: loaded value is not available until the load reaches W
    assign lwstall = MemtoRegE && (regMatch(rtE, rsD) || regMatch(rtE, rtD));

    // Branch compares in D: an ALU result still in E, or a load in M, cannot be forwarded yet
    assign brstall = branchD &&
                     ((RegWriteE && (regMatch(writeregE, rsD) || regMatch(writeregE, rtD))) ||
                      (MemtoRegM && (regMatch(writeregM, rsD) || regMatch(writeregM, rtD))));

    md_stall_fsm #(
        .MUL_CYCLES (MUL_CYCLES),
        .DIV_CYCLES (DIV_CYCLES),
        .CNT_W      (CNT_W)
    ) u_md (
        .clk      (clk),
        .reset    (reset),
        .mdstartE (mdstartE),
        .mdisdivE (mdisdivE),
        .mdstall  (mdstall),
        .mdbusy   (mdbusy),
        .hilo_weE (hilo_weE)
    );

    // While mult/div holds D/E, a D-stage hazard must not also bubble D/E;
    // it is re-evaluated once the unit releases
    assign stallF = lwstall | brstall | mdstall;
    assign stallD = lwstall | brstall | mdstall;
    assign stallE = mdstall;
    assign flushM = mdstall;
    assign flushE = (lwstall | brstall) & ~mdstall;

`ifdef HAZARD_PERF_EN
    logic [31:0] lwCntReg;
    logic [31:0] brCntReg;
    logic [31:0] mdCntReg;

    // Attribute each stalled cycle to exactly one cause: md over lw over br
    always_ff @(posedge clk) begin
        if (reset) begin
            lwCntReg <= '0;
            brCntReg <= '0;
            mdCntReg <= '0;
        end else if (mdstall) begin
            mdCntReg <= mdCntReg + 32'd1;
        end else if (lwstall) begin
            lwCntReg <= lwCntReg + 32'd1;
        end else if (brstall) begin
            brCntReg <= brCntReg + 32'd1;
        end
    end

    assign lw_stall_cnt = lwCntReg;
    assign br_stall_cnt = brCntReg;
    assign md_stall_cnt = mdCntReg;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios with literal
// expectations plus randomized traffic against a behavioural model.
// Build with HAZARD_PERF_EN defined to also check the stall counters.
module tb_hazard_ctrl;

    logic       clk;
    logic       reset;
    logic [4:0] rsD, rtD, rsE, rtE;
    logic [4:0] writeregE, writeregM, writeregW;
    logic       RegWriteE, RegWriteM, RegWriteW;
    logic       MemtoRegE, MemtoRegM;
    logic       branchD, mdstartE, mdisdivE;
    logic       stallF, stallD, stallE, flushE, flushM;
    logic [1:0] forwardAE, forwardBE;
    logic       forwardAD, forwardBD, mdbusy, hilo_weE;
`ifdef HAZARD_PERF_EN
    logic [31:0] lw_stall_cnt, br_stall_cnt, md_stall_cnt;
`endif

    hazard_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .rsD       (rsD),
        .rtD       (rtD),
        .rsE       (rsE),
        .rtE       (rtE),
        .writeregE (writeregE),
        .writeregM (writeregM),
        .writeregW (writeregW),
        .RegWriteE (RegWriteE),
        .RegWriteM (RegWriteM),
        .RegWriteW (RegWriteW),
        .MemtoRegE (MemtoRegE),
        .MemtoRegM (MemtoRegM),
        .branchD   (branchD),
        .mdstartE  (mdstartE),
        .mdisdivE  (mdisdivE),
        .stallF    (stallF),
        .stallD    (stallD),
        .stallE    (stallE),
        .flushE    (flushE),
        .flushM    (flushM),
        .forwardAE (forwardAE),
        .forwardBE (forwardBE),
        .forwardAD (forwardAD),
        .forwardBD (forwardBD),
        .mdbusy    (mdbusy),
        .hilo_weE  (hilo_weE)
`ifdef HAZARD_PERF_EN
        ,
        .lw_stall_cnt (lw_stall_cnt),
        .br_stall_cnt (br_stall_cnt),
        .md_stall_cnt (md_stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model of the mult/div unit: "age" is how many edges since the start was taken
    bit          mActive = 1'b0;
    int          mAge    = 0;
    int          mN      = 0;
    bit          lastHilo = 1'b0;
    int unsigned pLw = 0, pBr = 0, pMd = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit rm(input logic [4:0] a, input logic [4:0] b);
        return (a != 5'd0) && (a == b);
    endfunction

    task automatic clearIn();
        rsD = 0; rtD = 0; rsE = 0; rtE = 0;
        writeregE = 0; writeregM = 0; writeregW = 0;
        RegWriteE = 0; RegWriteM = 0; RegWriteW = 0;
        MemtoRegE = 0; MemtoRegM = 0; branchD = 0;
        mdstartE = 0; mdisdivE = 0;
    endtask

    function automatic int fwdSel(input logic [4:0] src);
        if (RegWriteM && rm(writeregM, src)) return 2;
        if (RegWriteW && rm(writeregW, src)) return 1;
        return 0;
    endfunction

    // Called right after inputs are driven at a negedge: compare every output
    // against the model, then advance the model across the next rising edge
    task automatic step();
        bit lwE, brE, mdE, hiE, useE;
        #1;
        lwE = MemtoRegE && (rm(rtE, rsD) || rm(rtE, rtD));
        brE = branchD && ((RegWriteE && (rm(writeregE, rsD) || rm(writeregE, rtD))) ||
                          (MemtoRegM && (rm(writeregM, rsD) || rm(writeregM, rtD))));
        mdE = (!mActive && mdstartE) || (mActive && mAge < mN);
        hiE = mActive && (mAge == mN);
        useE = lwE || brE;
        chk("m_stallF", stallF, useE || mdE);
        chk("m_stallD", stallD, useE || mdE);
        chk("m_stallE", stallE, mdE);
        chk("m_flushM", flushM, mdE);
        chk("m_flushE", flushE, useE && !mdE);
        chk("m_fwdAE", forwardAE, fwdSel(rsE));
        chk("m_fwdBE", forwardBE, fwdSel(rtE));
        chk("m_fwdAD", forwardAD, RegWriteM && rm(writeregM, rsD));
        chk("m_fwdBD", forwardBD, RegWriteM && rm(writeregM, rtD));
        chk("m_mdbusy", mdbusy, mActive);
        chk("m_hilo", hilo_weE, hiE);
`ifdef HAZARD_PERF_EN
        chk("m_lwcnt", lw_stall_cnt, pLw);
        chk("m_brcnt", br_stall_cnt, pBr);
        chk("m_mdcnt", md_stall_cnt, pMd);
`endif
        lastHilo = hiE;
        @(posedge clk);
        if (reset) begin
            mActive = 0;
            pLw = 0; pBr = 0; pMd = 0;
        end else begin
            if (mdE) pMd++;
            else if (lwE) pLw++;
            else if (brE) pBr++;
            if (!mActive) begin
                if (mdstartE) begin
                    mActive = 1;
                    mAge = 1;
                    mN = mdisdivE ? 32 : 4;
                end
            end else if (mAge == mN) begin
                mActive = 0;
            end else begin
                mAge++;
            end
        end
        @(negedge clk);
    endtask

    // Issue one mult/div, count stalled cycles and find the write-enable cycle
    task automatic mdRun(input bit isDiv, input int n, input string tag);
        int nst = 0;
        int hAt = 0;
        clearIn();
        mdstartE = 1;
        mdisdivE = isDiv;
        for (int i = 1; i <= n + 8 && hAt == 0; i++) begin
            #1;
            if (stallE) nst++;
            if (hilo_weE) hAt = i;
            step();
        end
        mdstartE = 0;
        #1;
        chk({tag, "_stalls"}, nst, n);
        chk({tag, "_hilo_cycle"}, hAt, n + 1);
        chk({tag, "_norestart"}, mdbusy, 0);
        step();
        $display("%s: stalls=%0d hilo_cycle=%0d", tag, nst, hAt);
    endtask

    initial begin
        int hiloCnt;
        int ops = 0;
        clearIn();
        reset = 1;
        @(negedge clk);
        step();
        reset = 0;
        #1;
        chk("rst_stallF", stallF, 0);
        chk("rst_stallE", stallE, 0);
        chk("rst_flushE", flushE, 0);
        chk("rst_flushM", flushM, 0);
        chk("rst_mdbusy", mdbusy, 0);
        chk("rst_hilo", hilo_weE, 0);
`ifdef HAZARD_PERF_EN
        chk("rst_mdcnt", md_stall_cnt, 0);
`endif
        step();
        $display("reset: outputs idle");

        // lw $2 in E, consumer of $2 in D
        MemtoRegE = 1; rtE = 5'd2; rsD = 5'd2;
        #1;
        chk("lw_stallF", stallF, 1);
        chk("lw_stallD", stallD, 1);
        chk("lw_flushE", flushE, 1);
        step();
        clearIn();
        RegWriteW = 1; writeregW = 5'd2; rsE = 5'd2;
        #1;
        chk("lw_fwdW", forwardAE, 1);
        chk("lw_released", stallD, 0);
        step();
        $display("load-use: one stall then W forward");

        // M result beats W result; $0 never forwards
        clearIn();
        RegWriteM = 1; writeregM = 5'd5; RegWriteW = 1; writeregW = 5'd5; rsE = 5'd5;
        #1;
        chk("fwd_Mwins", forwardAE, 2);
        writeregM = 5'd0; rsE = 5'd0;
        #1;
        chk("fwd_reg0", forwardAE, 0);
        step();
        $display("forward: M priority and r0 exclusion");

        // beq with operand still being computed in E
        clearIn();
        branchD = 1; rsD = 5'd3; RegWriteE = 1; writeregE = 5'd3;
        #1;
        chk("br_stallD", stallD, 1);
        chk("br_flushE", flushE, 1);
        step();
        clearIn();
        branchD = 1; rsD = 5'd3; RegWriteM = 1; writeregM = 5'd3;
        #1;
        chk("br_fwdAD", forwardAD, 1);
        chk("br_released", stallD, 0);
        step();
        $display("branch: one stall then M forward to comparator");

        mdRun(1'b1, 32, "div");
        mdRun(1'b0, 4, "mult");
`ifdef HAZARD_PERF_EN
        #1;
        chk("perf_lw", lw_stall_cnt, 1);
        chk("perf_br", br_stall_cnt, 1);
        chk("perf_md", md_stall_cnt, 36);
        $display("perf: lw=%0d br=%0d md=%0d", lw_stall_cnt, br_stall_cnt, md_stall_cnt);
`endif

        // div in flight with a load-use hazard, then killed by reset at cnt=10
        clearIn();
        mdstartE = 1; mdisdivE = 1;
        MemtoRegE = 1; rtE = 5'd2; rsD = 5'd2;
        for (int i = 0; i < 22; i++) begin
            #1;
            chk("mdprio_flushE", flushE, 0);
            chk("mdprio_stallE", stallE, 1);
            step();
        end
        reset = 1; mdstartE = 0;
        step();
        reset = 0;
        #1;
        chk("mdrst_busy", mdbusy, 0);
        chk("mdrst_stallE", stallE, 0);
        chk("mdrst_flushE", flushE, 1);
        hiloCnt = 0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (hilo_weE) hiloCnt++;
            step();
        end
        chk("mdrst_nohilo", hiloCnt, 0);
        $display("md reset: aborted without hilo pulse");

        // Randomized traffic: small register numbers to provoke matches
        clearIn();
        for (int c = 0; c < 3000; c++) begin
            rsD = 5'($urandom_range(0, 3));
            rtD = 5'($urandom_range(0, 3));
            rsE = 5'($urandom_range(0, 3));
            rtE = 5'($urandom_range(0, 3));
            writeregE = 5'($urandom_range(0, 3));
            writeregM = 5'($urandom_range(0, 3));
            writeregW = 5'($urandom_range(0, 3));
            RegWriteE = 1'($urandom_range(0, 1));
            RegWriteM = 1'($urandom_range(0, 1));
            RegWriteW = 1'($urandom_range(0, 1));
            MemtoRegE = 1'($urandom_range(0, 1));
            MemtoRegM = 1'($urandom_range(0, 1));
            branchD   = 1'($urandom_range(0, 1));
            reset     = ($urandom_range(0, 63) == 0);
            if (reset) begin
                mdstartE = 0;
            end else if (lastHilo && mdstartE) begin
                mdstartE = 0;
                ops++;
                $display("random md op %0d complete (%s)", ops, mdisdivE ? "div" : "mult");
            end else if (!mdstartE && $urandom_range(0, 9) == 0) begin
                mdstartE = 1;
                mdisdivE = 1'($urandom_range(0, 1));
            end
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
